des_decrypt_iter: RTL and testbench



---
 rtl/des_pkg.sv | 98 +++++++++
 rtl/des_decrypt_iter_if.sv | 29 ++
 rtl/des_decrypt_iter_feistel.sv | 90 +++++++++
 rtl/des_decrypt_iter.sv | 116 +++++++++++
 tb/tb_des_decrypt_iter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES constants and helpers for the encrypt and decrypt cores:
//   - fixed geometry (block width, round count, round-counter width)
//   - core state enum
//   - IP, IP^-1, PC1 and PC2 permutation tables plus functions that apply them
//   - the encrypt-direction key-rotation table (1 or 2 bits per round)
// Bit numbering: DES bit 1 is the MSB of every vector.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int BLOCK_W    = 64;
    localparam int NUM_ROUNDS = 16;
    localparam int ROUND_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TBL [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Parity bits (8, 16, ... 64) never appear here, so they are ignored.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied before round k (index k-1) on encryption.
    localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_TBL[i]];
        return y;
    endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// -----------------------------------------------------------------------------
// des_decrypt_iter_if
// Handshake bundle for the DES decrypt core.
//   in_valid/in_ready/in_block/in_key    : ciphertext + key acceptance
//   out_valid/out_ready/out_block        : plaintext delivery
// master = block source / plaintext consumer, slave = the core.
// -----------------------------------------------------------------------------
interface des_decrypt_iter_if;
    import des_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_block;
    logic [BLOCK_W-1:0] in_key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/des_decrypt_iter_feistel.sv
// -----------------------------------------------------------------------------
// des_decrypt_iter_feistel
// DES round function f(R, K): expansion E, key mix, eight S-boxes, permutation P.
// Purely combinational; shared by the encrypt and decrypt cores.
//   half_block : 32-bit right half R
//   subkey     : 48-bit round key
//   result     : 32-bit f(R, K)
// -----------------------------------------------------------------------------
module des_decrypt_iter_feistel (
    input  logic [31:0] half_block,
    input  logic [47:0] subkey,
    output logic [31:0] result
);

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // S1..S8, each 4 rows x 16 columns, row-major.
    localparam int SBOX_TBL [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    logic [47:0] expanded;
    logic [47:0] mixed;
    logic [31:0] sbox_out;

    always_comb begin
        expanded = '0;
        for (int i = 0; i < 48; i++) expanded[47-i] = half_block[32-E_TBL[i]];
    end

    assign mixed = expanded ^ subkey;

    // Each S-box: outer bits (b1,b6) pick the row, inner four bits the column.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sbox
            logic [5:0] six;
            assign six = mixed[47-6*gi -: 6];
            assign sbox_out[31-4*gi -: 4] =
                4'(SBOX_TBL[gi*64 + int'({six[5], six[0], six[4:1]})]);
        end
    endgenerate

    always_comb begin
        result = '0;
        for (int i = 0; i < 32; i++) result[31-i] = sbox_out[32-P_TBL[i]];
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// -----------------------------------------------------------------------------
// des_decrypt_iter
// Iterative DES decryption: one Feistel round per clock, 16 rounds per block.
// Subkeys run K16..K1, produced by right-rotating the PC1 halves each round.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : des_decrypt_iter_if.slave
//          in_valid/in_ready/in_block/in_key  ciphertext + key in
//          out_valid/out_ready/out_block      plaintext out
// -----------------------------------------------------------------------------
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    des_decrypt_iter_if.slave bus
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    state_t             state_reg;
    state_t             state_next;
    logic [ROUND_W-1:0] round_reg;
    logic [31:0]        l_reg;
    logic [31:0]        r_reg;
    logic [27:0]        cd_reg  [2];    // [0] = C, [1] = D
    logic [27:0]        cd_next [2];
    logic [47:0]        subkey;
    logic [31:0]        f_out;
    logic [3:0]         key_idx;
    logic               shift_two;
    logic               accept;
    logic [63:0]        block_perm;
    logic [55:0]        key_perm;

    assign accept     = (state_reg == ST_IDLE) && bus.in_valid;
    assign block_perm = ip(bus.in_block);
    assign key_perm   = pc1(bus.in_key);

    // PC1 output already equals C16/D16 (the encrypt rotations sum to 28),
    // so round r uses K(17-r) straight from the current halves and then undoes
    // the encrypt rotation of that same key index.
    assign subkey    = pc2({cd_reg[0], cd_reg[1]});
    assign key_idx   = 4'(LAST_ROUND - round_reg);
    assign shift_two = (SHIFT_TBL[key_idx] == 2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rot
            assign cd_next[gi] = shift_two ? {cd_reg[gi][1:0], cd_reg[gi][27:2]}
                                           : {cd_reg[gi][0],   cd_reg[gi][27:1]};
        end
    endgenerate

    des_decrypt_iter_feistel u_feistel (
        .half_block (r_reg),
        .subkey     (subkey),
        .result     (f_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.in_valid)              state_next = ST_ROUND;
            ST_ROUND: if (round_reg == LAST_ROUND)   state_next = ST_DONE;
            ST_DONE:  if (bus.out_ready)             state_next = ST_IDLE;
            default:                                 state_next = ST_IDLE;
        endcase
    end

    // Outputs depend on registers only; plaintext is gated to zero outside DONE.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_block = '0;
        case (state_reg)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_block = fp({r_reg, l_reg});
            end
            default: ;
        endcase
    end

    // Datapath: load on acceptance, one round per cycle in ROUND, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_reg <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            cd_reg[0] <= '0;
            cd_reg[1] <= '0;
        end else if (accept) begin
            l_reg     <= block_perm[63:32];
            r_reg     <= block_perm[31:0];
            cd_reg[0] <= key_perm[55:28];
            cd_reg[1] <= key_perm[27:0];
            round_reg <= ROUND_W'(1);
        end else if (state_reg == ST_ROUND) begin
            l_reg     <= r_reg;
            r_reg     <= l_reg ^ f_out;
            cd_reg[0] <= cd_next[0];
            cd_reg[1] <= cd_next[1];
            round_reg <= round_reg + ROUND_W'(1);
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_des_decrypt_iter
// Self-checking bench for des_decrypt_iter. Expected plaintexts are pushed to a
// scoreboard queue at acceptance and popped when the core delivers output.
// Random vectors come from an independent DES encryption model below.
// Latency is counted with the accepting edge as edge 1.
// -----------------------------------------------------------------------------
module tb_des_decrypt_iter;

    localparam int M_IP [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int M_FP [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int M_PC1 [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int M_PC2 [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int M_E [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int M_P [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int M_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int M_SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    logic clk = 1'b0;
    logic rst;
    des_decrypt_iter_if bus();

    des_decrypt_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    int          accept_cyc = 0;
    logic [63:0] exp_q [$];

    // ---------------- reference model: classic DES encryption ----------------
    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        int          row;
        int          col;
        e = '0; s = '0; y = '0;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-M_E[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            six = e[47-6*j -: 6];
            row = {six[5], six[0]};
            col = six[4:1];
            s[31-4*j -: 4] = 4'(M_SBOX[j*64 + row*16 + col]);
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-M_P[i]];
        return y;
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] ks [16];
        logic [63:0] x;
        logic [63:0] y;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        cd = '0; x = '0; y = '0;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-M_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < M_SHIFT[k]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            ks[k] = '0;
            for (int i = 0; i < 48; i++) ks[k][47-i] = cd[56-M_PC2[i]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = pt[64-M_IP[i]];
        l = x[63:32];
        r = x[31:0];
        for (int k = 0; k < 16; k++) begin
            t = r;
            r = l ^ m_f(r, ks[k]);
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63-i] = x[64-M_FP[i]];
        return y;
    endfunction

    // ---------------- drive / observe helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block until accepted; afterwards the inputs are scrambled so
    // a core that samples late produces a wrong result.
    task automatic send(input logic [63:0] key, input logic [63:0] ct, input logic [63:0] pt);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        bus.in_key   = key;
        bus.in_block = ct;
        bus.in_valid = 1'b1;
        while (!took && n < 100) begin
            took = (bus.in_ready === 1'b1);
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_key   = {$urandom, $urandom};
        bus.in_block = {$urandom, $urandom};
        if (took) begin
            accept_cyc = cyc;
            exp_q.push_back(pt);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, required 1", bus.in_ready, n);
        end
    endtask

    task automatic wait_out(output logic [63:0] blk, output int lat, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        blk = '0;
        lat = 0;
        while (!ok && n < 100) begin
            if (bus.out_valid === 1'b1) begin
                ok  = 1'b1;
                blk = bus.out_block;
                lat = cyc - accept_cyc + 1;
            end else begin
                step();
                n++;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        n_vec++;
        if (bus.out_block !== 64'h0) begin
            n_err++; $display("FAIL reset_out_block: got %h, required 0", bus.out_block);
        end
        $display("txn reset: in_ready=%b out_valid=%b out_block=%h", bus.in_ready, bus.out_valid, bus.out_block);
    endtask

    task automatic test_known_answers();
        logic [63:0] k_key [4] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73,
                                   64'h0F339333EB6C0C72, 64'h0000000000000000};
        logic [63:0] k_ct  [4] = '{64'h85E813540F0AB405, 64'h0000000000000000,
                                   64'h0000000000000000, 64'h8CA64DE9C1B123A7};
        logic [63:0] k_pt  [4] = '{64'h0123456789ABCDEF, 64'h8787878787878787,
                                   64'h8787878787878787, 64'h0000000000000000};
        logic [63:0] blk;
        logic [63:0] expv;
        int          lat;
        bit          ok;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(k_key[i], k_ct[i], k_pt[i]);
            wait_out(blk, lat, ok);
            if (ok) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                n_vec++;
                if (blk !== expv) begin
                    n_err++; $display("FAIL kat%0d_block: got %h, required %h", i, blk, expv);
                end
                n_vec++;
                if (lat != 17) begin
                    n_err++; $display("FAIL kat%0d_latency: got %0d edges, required 17", i, lat);
                end
                step();
                n_vec++;
                if (bus.out_valid !== 1'b0) begin
                    n_err++; $display("FAIL kat%0d_release: out_valid=%b after handshake, required 0", i, bus.out_valid);
                end
                $display("txn kat%0d: key=%h ct=%h out=%h lat=%0d", i, k_key[i], k_ct[i], blk, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] blk0;
        logic [63:0] blk1;
        logic [63:0] expv;
        int          lat;
        int          hs_cyc;
        bit          ok;
        bus.out_ready = 1'b0;
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
        // Second block offered while the first is still in flight.
        bus.in_key   = 64'h0E329232EA6D0D73;
        bus.in_block = 64'h0000000000000000;
        bus.in_valid = 1'b1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_ready_in_round: got %b, required 0", bus.in_ready);
        end
        wait_out(blk0, lat, ok);
        if (!ok) return;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (bus.out_block !== blk0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: out_block=%h in_ready=%b out_valid=%b, required %h 0 1",
                         i, bus.out_block, bus.in_ready, bus.out_valid, blk0);
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        hs_cyc = cyc;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_vec++;
        if (blk0 !== expv) begin
            n_err++; $display("FAIL bp_first_block: got %h, required %h", blk0, expv);
        end
        $display("txn bp_first: out=%h", blk0);
        send(64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787);
        n_vec++;
        if (accept_cyc != hs_cyc + 1) begin
            n_err++; $display("FAIL bp_second_accept: accepted at cycle %0d, required %0d", accept_cyc, hs_cyc + 1);
        end
        wait_out(blk1, lat, ok);
        if (!ok) return;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_vec++;
        if (blk1 !== expv) begin
            n_err++; $display("FAIL bp_second_block: got %h, required %h", blk1, expv);
        end
        step();
        $display("txn bp_second: out=%h", blk1);
    endtask

    task automatic test_reset_mid_round();
        logic [63:0] key_a;
        logic [63:0] pt_a;
        logic [63:0] blk;
        logic [63:0] expv;
        int          lat;
        bit          ok;
        key_a = {$urandom, $urandom};
        pt_a  = {$urandom, $urandom};
        bus.out_ready = 1'b1;
        send(key_a, m_encrypt(pt_a, key_a), pt_a);
        repeat (7) step();
        rst = 1'b1;
        bus.in_key   = 64'h0000000000000000;
        bus.in_block = 64'h8CA64DE9C1B123A7;
        bus.in_valid = 1'b1;
        step();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_block !== 64'h0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_outputs: out_valid=%b out_block=%h in_ready=%b, required 0 0 1",
                     bus.out_valid, bus.out_block, bus.in_ready);
        end
        exp_q.delete();
        rst = 1'b0;
        send(64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000);
        wait_out(blk, lat, ok);
        if (!ok) return;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_vec++;
        if (blk !== expv) begin
            n_err++; $display("FAIL midrst_next_block: got %h, required %h", blk, expv);
        end
        n_vec++;
        if (lat != 17) begin
            n_err++; $display("FAIL midrst_latency: got %0d edges, required 17", lat);
        end
        step();
        $display("txn midrst: out=%h lat=%0d", blk, lat);
    endtask

    task automatic test_back_to_back();
        logic [63:0] key;
        logic [63:0] pt;
        logic [63:0] blk;
        logic [63:0] expv;
        int          lat;
        int          prev;
        bit          ok;
        bus.out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 100; i++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            send(key, m_encrypt(pt, key), pt);
            if (prev >= 0) begin
                n_vec++;
                if (accept_cyc - prev != 18) begin
                    n_err++; $display("FAIL b2b%0d_period: got %0d cycles, required 18", i, accept_cyc - prev);
                end
            end
            prev = accept_cyc;
            wait_out(blk, lat, ok);
            if (!ok) return;
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
            n_vec++;
            if (blk !== expv) begin
                n_err++; $display("FAIL b2b%0d_block: got %h, required %h", i, blk, expv);
            end
            step();
            $display("txn b2b%0d: key=%h out=%h", i, key, blk);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_known_answers();
        test_backpressure();
        test_reset_mid_round();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
